branch_resolve_unit: RTL and testbench

Downstream consumer of the 8-bit comparator code (0x00 equal, 0x01 greater, 0xFF less). Captures the comparison into a flag register, resolves conditional branches against those flags, and owns the 8-bit program counter. It asserts a fixed-length redirect pulse so fetch and decode can flush after a taken branch.

---
 rtl/branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_branch_resolve_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: flag capture, branch resolution, PC and redirect pulse; BRANCH_STATS_EN adds taken/not-taken counters
module branch_resolve_unit #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      cmp_in,
  input  logic            cmp_valid,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      flags,
  output logic            flags_vld,
  output logic            redirect,
  output logic            cmp_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [7:0]      taken_cnt,
  output logic [7:0]      nottaken_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, target_q, target_d, cur_target;
  logic [2:0] flags_q, flags_d, cond_q, cond_d, cur_cond, cmp_flags;
  logic [3:0] cnt_q, cnt_d;
  logic flags_vld_q, flags_vld_d, cmp_err_q, cmp_err_d, redirect_q, redirect_d;
  logic cmp_legal, in_wait, uncond, accept, resolve, hold, taken;
`ifdef BRANCH_STATS_EN
  logic [7:0] taken_cnt_q, taken_cnt_d, nottaken_cnt_q, nottaken_cnt_d;
`endif
  function automatic logic eval(input logic [2:0] c, input logic [2:0] f);
    logic [7:0] tbl;
    tbl = {1'b0, f[2] | f[0], f[1] | f[0], f[2], f[1], !f[0], f[0], 1'b1};
    return tbl[c];
  endfunction
  always_comb begin
    cmp_legal = cmp_valid && (cmp_in == 8'h00 || cmp_in == 8'h01 || cmp_in == 8'hff);
    cmp_flags = cmp_in == 8'h00 ? 3'b001 : cmp_in == 8'h01 ? 3'b010 : 3'b100;
    in_wait = state_q == WAIT;
    cur_cond = in_wait ? cond_q : br_cond;
    cur_target = in_wait ? target_q : br_target;
    uncond = cur_cond == 3'b000 || cur_cond == 3'b111;
    accept = br_valid && state_q == IDLE;
    resolve = in_wait ? cmp_legal : accept && (uncond || flags_vld_q || cmp_legal);
    hold = accept && !resolve;
    taken = resolve && eval(cur_cond, cmp_legal ? cmp_flags : flags_q);
    flags_d = cmp_legal ? cmp_flags : flags_q;
    flags_vld_d = cmp_legal || (flags_vld_q && !(resolve && !uncond));
    cmp_err_d = cmp_err_q || (cmp_valid && !cmp_legal);
    cond_d = hold ? br_cond : cond_q;
    target_d = hold ? br_target : target_q;
    pc_d = taken ? cur_target
         : !stall && ((state_q == IDLE && !hold) || (in_wait && resolve)) ? pc_q + PC_W'(1)
         : pc_q;
    state_d = taken ? FLUSH
            : hold ? WAIT
            : in_wait && resolve ? IDLE
            : state_q == FLUSH && cnt_q == 4'd0 ? IDLE
            : state_q;
    cnt_d = taken ? FLUSH_INIT : state_q == FLUSH ? cnt_q - 4'd1 : cnt_q;
    redirect_d = state_d == FLUSH;
`ifdef BRANCH_STATS_EN
    taken_cnt_d = taken && taken_cnt_q != 8'hff ? taken_cnt_q + 8'd1 : taken_cnt_q;
    nottaken_cnt_d = resolve && !taken && nottaken_cnt_q != 8'hff ? nottaken_cnt_q + 8'd1 : nottaken_cnt_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      flags_q <= 3'b000;
      flags_vld_q <= 1'b0;
      cmp_err_q <= 1'b0;
      redirect_q <= 1'b0;
      cond_q <= 3'b000;
      target_q <= '0;
      cnt_q <= 4'd0;
`ifdef BRANCH_STATS_EN
      taken_cnt_q <= 8'd0;
      nottaken_cnt_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      flags_q <= flags_d;
      flags_vld_q <= flags_vld_d;
      cmp_err_q <= cmp_err_d;
      redirect_q <= redirect_d;
      cond_q <= cond_d;
      target_q <= target_d;
      cnt_q <= cnt_d;
`ifdef BRANCH_STATS_EN
      taken_cnt_q <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
`endif
    end
  end
  assign br_ready = state_q == IDLE;
  assign pc = pc_q;
  assign flags = flags_q;
  assign flags_vld = flags_vld_q;
  assign redirect = redirect_q;
  assign cmp_err = cmp_err_q;
`ifdef BRANCH_STATS_EN
  assign taken_cnt = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of branch_resolve_unit with RESET_PC=0x10, FLUSH_CYCLES=2
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] cmp_in = 8'h00;
  logic cmp_valid = 1'b0;
  logic br_valid = 1'b0;
  logic br_ready;
  logic [2:0] br_cond = 3'b000;
  logic [7:0] br_target = 8'h00;
  logic stall = 1'b0;
  logic [7:0] pc;
  logic [2:0] flags;
  logic flags_vld, redirect, cmp_err;
`ifdef BRANCH_STATS_EN
  logic [7:0] taken_cnt, nottaken_cnt;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  branch_resolve_unit #(.PC_W(8), .RESET_PC(8'h10), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .cmp_in(cmp_in), .cmp_valid(cmp_valid),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .stall(stall), .pc(pc), .flags(flags), .flags_vld(flags_vld),
    .redirect(redirect), .cmp_err(cmp_err)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (pc !== 8'h10) begin n_bad++; $display("FAIL reset_pc: got %h want 10", pc); end
    n_cmp++; if (flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", flags); end
    n_cmp++; if (flags_vld !== 1'b0) begin n_bad++; $display("FAIL reset_flags_vld: got %b want 0", flags_vld); end
    n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    n_cmp++; if (br_ready !== 1'b1) begin n_bad++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
    n_cmp++; if (cmp_err !== 1'b0) begin n_bad++; $display("FAIL reset_cmp_err: got %b want 0", cmp_err); end
    tick();
    n_cmp++; if (pc !== 8'h11) begin n_bad++; $display("FAIL inc_pc1: got %h want 11", pc); end
    tick();
    n_cmp++; if (pc !== 8'h12) begin n_bad++; $display("FAIL inc_pc2: got %h want 12", pc); end
    tick();
    n_cmp++; if (pc !== 8'h13) begin n_bad++; $display("FAIL inc_pc3: got %h want 13", pc); end
    n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL inc_redirect: got %b want 0", redirect); end
  endtask
  task automatic test_taken_gt;
    do_reset();
    cmp_in = 8'h01; cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    n_cmp++; if (flags !== 3'b010) begin n_bad++; $display("FAIL gt_flags: got %b want 010", flags); end
    n_cmp++; if (flags_vld !== 1'b1) begin n_bad++; $display("FAIL gt_flags_vld: got %b want 1", flags_vld); end
    n_cmp++; if (pc !== 8'h11) begin n_bad++; $display("FAIL gt_pc_pre: got %h want 11", pc); end
    br_valid = 1'b1; br_cond = 3'b011; br_target = 8'h40;
    #1;
    n_cmp++; if (br_ready !== 1'b1) begin n_bad++; $display("FAIL gt_ready_accept: got %b want 1", br_ready); end
    tick();
    br_valid = 1'b0;
    n_cmp++; if (pc !== 8'h40) begin n_bad++; $display("FAIL gt_pc_target: got %h want 40", pc); end
    n_cmp++; if (redirect !== 1'b1) begin n_bad++; $display("FAIL gt_redirect1: got %b want 1", redirect); end
    n_cmp++; if (br_ready !== 1'b0) begin n_bad++; $display("FAIL gt_ready1: got %b want 0", br_ready); end
    n_cmp++; if (flags_vld !== 1'b0) begin n_bad++; $display("FAIL gt_consumed: got %b want 0", flags_vld); end
`ifdef BRANCH_STATS_EN
    n_cmp++; if (taken_cnt !== 8'd1) begin n_bad++; $display("FAIL gt_taken_cnt: got %0d want 1", taken_cnt); end
`endif
    tick();
    n_cmp++; if (redirect !== 1'b1) begin n_bad++; $display("FAIL gt_redirect2: got %b want 1", redirect); end
    n_cmp++; if (br_ready !== 1'b0) begin n_bad++; $display("FAIL gt_ready2: got %b want 0", br_ready); end
    n_cmp++; if (pc !== 8'h40) begin n_bad++; $display("FAIL gt_pc_hold: got %h want 40", pc); end
    tick();
    n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL gt_redirect_end: got %b want 0", redirect); end
    n_cmp++; if (br_ready !== 1'b1) begin n_bad++; $display("FAIL gt_ready_back: got %b want 1", br_ready); end
    n_cmp++; if (pc !== 8'h40) begin n_bad++; $display("FAIL gt_pc_hold2: got %h want 40", pc); end
    tick();
    n_cmp++; if (pc !== 8'h41) begin n_bad++; $display("FAIL gt_pc_resume: got %h want 41", pc); end
  endtask
  task automatic test_wait;
    do_reset();
    br_valid = 1'b1; br_cond = 3'b001; br_target = 8'h80;
    tick();
    br_valid = 1'b0;
    n_cmp++; if (br_ready !== 1'b0) begin n_bad++; $display("FAIL wait_ready: got %b want 0", br_ready); end
    n_cmp++; if (pc !== 8'h10) begin n_bad++; $display("FAIL wait_pc0: got %h want 10", pc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc !== 8'h10 || br_ready !== 1'b0 || redirect !== 1'b0) begin n_bad++; $display("FAIL wait_idle%0d: pc %h ready %b redirect %b want 10 0 0", i, pc, br_ready, redirect); end
    end
    cmp_in = 8'h37; cmp_valid = 1'b1;
    tick();
    n_cmp++; if (br_ready !== 1'b0 || pc !== 8'h10) begin n_bad++; $display("FAIL wait_illegal: ready %b pc %h want 0 10", br_ready, pc); end
    n_cmp++; if (cmp_err !== 1'b1) begin n_bad++; $display("FAIL wait_cmp_err: got %b want 1", cmp_err); end
    cmp_in = 8'hff;
    tick();
    cmp_valid = 1'b0;
    n_cmp++; if (pc !== 8'h11) begin n_bad++; $display("FAIL wait_pc_inc: got %h want 11", pc); end
    n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL wait_redirect: got %b want 0", redirect); end
    n_cmp++; if (br_ready !== 1'b1) begin n_bad++; $display("FAIL wait_ready_back: got %b want 1", br_ready); end
    n_cmp++; if (flags !== 3'b100 || flags_vld !== 1'b1) begin n_bad++; $display("FAIL wait_flags: got %b/%b want 100/1", flags, flags_vld); end
    tick();
    n_cmp++; if (pc !== 8'h12) begin n_bad++; $display("FAIL wait_pc_next: got %h want 12", pc); end
  endtask
  task automatic test_cmp_err;
    do_reset();
    n_cmp++; if (cmp_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared_pre: got %b want 0", cmp_err); end
    cmp_in = 8'h01; cmp_valid = 1'b1;
    tick();
    cmp_in = 8'h37;
    tick();
    cmp_valid = 1'b0;
    n_cmp++; if (cmp_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", cmp_err); end
    n_cmp++; if (flags !== 3'b010 || flags_vld !== 1'b1) begin n_bad++; $display("FAIL err_flags_kept: got %b/%b want 010/1", flags, flags_vld); end
    tick();
    tick();
    n_cmp++; if (cmp_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", cmp_err); end
    do_reset();
    n_cmp++; if (cmp_err !== 1'b0) begin n_bad++; $display("FAIL err_reset: got %b want 0", cmp_err); end
  endtask
  task automatic test_wrap_stall;
    do_reset();
    br_valid = 1'b1; br_cond = 3'b000; br_target = 8'hfe;
    tick();
    br_valid = 1'b0;
    n_cmp++; if (pc !== 8'hfe) begin n_bad++; $display("FAIL wrap_pc_fe: got %h want fe", pc); end
    tick();
    tick();
    tick();
    n_cmp++; if (pc !== 8'hff) begin n_bad++; $display("FAIL wrap_pc_ff: got %h want ff", pc); end
    tick();
    n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL wrap_pc_00: got %h want 00", pc); end
    stall = 1'b1;
    tick();
    n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL stall_hold: got %h want 00", pc); end
    br_valid = 1'b1; br_cond = 3'b000; br_target = 8'h05;
    tick();
    br_valid = 1'b0;
    n_cmp++; if (pc !== 8'h05) begin n_bad++; $display("FAIL stall_override: got %h want 05", pc); end
    tick();
    tick();
    tick();
    n_cmp++; if (pc !== 8'h05 || br_ready !== 1'b1) begin n_bad++; $display("FAIL stall_after: pc %h ready %b want 05 1", pc, br_ready); end
    stall = 1'b0;
  endtask
  task automatic test_conditions;
    do_reset();
    cmp_in = 8'h00; cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    br_valid = 1'b1; br_cond = 3'b111; br_target = 8'h99;
    tick();
    n_cmp++; if (pc !== 8'h12 || redirect !== 1'b0) begin n_bad++; $display("FAIL never_pc: pc %h redirect %b want 12 0", pc, redirect); end
    n_cmp++; if (flags_vld !== 1'b1) begin n_bad++; $display("FAIL never_keep_flags: got %b want 1", flags_vld); end
    br_cond = 3'b010;
    tick();
    n_cmp++; if (pc !== 8'h13 || redirect !== 1'b0) begin n_bad++; $display("FAIL ne_not_taken: pc %h redirect %b want 13 0", pc, redirect); end
    n_cmp++; if (flags_vld !== 1'b0) begin n_bad++; $display("FAIL ne_consume: got %b want 0", flags_vld); end
    br_cond = 3'b101; br_target = 8'h22; cmp_in = 8'h01; cmp_valid = 1'b1;
    tick();
    br_valid = 1'b0; cmp_valid = 1'b0;
    n_cmp++; if (pc !== 8'h22 || redirect !== 1'b1) begin n_bad++; $display("FAIL ge_bypass: pc %h redirect %b want 22 1", pc, redirect); end
    n_cmp++; if (flags !== 3'b010 || flags_vld !== 1'b1) begin n_bad++; $display("FAIL ge_bypass_flags: got %b/%b want 010/1", flags, flags_vld); end
    tick();
    tick();
  endtask
  task automatic test_reset_flush;
    do_reset();
    br_valid = 1'b1; br_cond = 3'b000; br_target = 8'h30;
    tick();
    br_valid = 1'b0;
    n_cmp++; if (redirect !== 1'b1 || pc !== 8'h30) begin n_bad++; $display("FAIL rf_flush: redirect %b pc %h want 1 30", redirect, pc); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (redirect !== 1'b0) begin n_bad++; $display("FAIL rf_redirect: got %b want 0", redirect); end
    n_cmp++; if (pc !== 8'h10) begin n_bad++; $display("FAIL rf_pc: got %h want 10", pc); end
    n_cmp++; if (br_ready !== 1'b1) begin n_bad++; $display("FAIL rf_ready: got %b want 1", br_ready); end
`ifdef BRANCH_STATS_EN
    n_cmp++; if (taken_cnt !== 8'd0 || nottaken_cnt !== 8'd0) begin n_bad++; $display("FAIL rf_counters: got %0d/%0d want 0/0", taken_cnt, nottaken_cnt); end
`endif
    tick();
    n_cmp++; if (pc !== 8'h11 || redirect !== 1'b0) begin n_bad++; $display("FAIL rf_resume: pc %h redirect %b want 11 0", pc, redirect); end
  endtask
  initial begin
    test_reset();
    test_taken_gt();
    test_wait();
    test_cmp_err();
    test_wrap_stall();
    test_conditions();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
